serial_sub_ctrl: RTL and testbench

- Controller that sequences a 1-bit subtract cell bit-serially, LSB first, to compute an N-bit difference a - b with final borrow.
- The cell is half-subtractor based (two half subtractors plus an OR form the borrow-chained stage).
- Sits between a requester using a start/busy/done handshake and the 1-bit datapath.
- Owns operand latching, bit indexing, borrow chaining and result hold.

---
 rtl/serial_sub_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtractor controller. It latches two WIDTH-bit operands on an
// accepted start, steps a 1-bit borrow-chained subtract cell across them LSB
// first (one bit per clock), then presents the difference and the final borrow
// and pulses done for one cycle.
//
// The 1-bit cell is two half subtractors plus an OR:
//   hs1 : d1 = a ^ b,   b1 = ~a & b
//   hs2 : d  = d1 ^ br, b2 = ~d1 & br
//   bout = b1 | b2
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst    : synchronous active-high reset, priority over all other inputs
//   start  : operation request, only looked at while idle
//   a, b   : minuend / subtrahend, captured when start is accepted
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, sub/borrow valid
//   sub    : (a - b) mod 2^WIDTH, held until the next op completes or reset
//   borrow : 1 iff a < b (unsigned), held like sub
//
// Timing for an op accepted at edge E0: busy is high for the WIDTH cycles
// after E0, done is high in the cycle after edge E_WIDTH, and the next start
// can be accepted at E0+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sub,
  output logic             borrow
);

  // One extra counter bit so the index never wraps, even at WIDTH=32.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] sub_reg, sub_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             br_reg, br_next;
  logic             borrow_reg, borrow_next;

  // ---------------------------------------------------------------------------
  // 1-bit subtract cell. The operand registers shift right while running, so
  // the bit under process is always bit 0.
  // ---------------------------------------------------------------------------
  logic cell_a, cell_b;
  logic hs1_d, hs1_b;
  logic hs2_d, hs2_b;
  logic cell_d, cell_bout;

  assign cell_a    = a_reg[0];
  assign cell_b    = b_reg[0];
  assign hs1_d     = cell_a ^ cell_b;
  assign hs1_b     = ~cell_a & cell_b;
  assign hs2_d     = hs1_d ^ br_reg;
  assign hs2_b     = ~hs1_d & br_reg;
  assign cell_d    = hs2_d;
  assign cell_bout = hs1_b | hs2_b;

  // ---------------------------------------------------------------------------
  // Result shift register: each new difference bit enters at the MSB and the
  // rest move down. After WIDTH shifts the first (LSB) bit has reached bit 0,
  // so the register holds the difference in natural order. Built per bit so
  // WIDTH=1 needs no special-case slicing.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sr_shift;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign sr_shift[gi] = cell_d;
      end else begin : g_mid
        assign sr_shift[gi] = sr_reg[gi+1];
      end
    end
  endgenerate

  logic last_bit;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    sr_next     = sr_reg;
    cnt_next    = cnt_reg;
    br_next     = br_reg;
    sub_next    = sub_reg;
    borrow_next = borrow_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          sr_next    = '0;
          cnt_next   = '0;
          br_next    = 1'b0;
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        // start and the a/b inputs are deliberately not looked at here.
        a_next   = a_reg >> 1;
        b_next   = b_reg >> 1;
        br_next  = cell_bout;
        sr_next  = sr_shift;
        cnt_next = cnt_reg + CW'(1);
        if (last_bit) begin
          // Publish the result on the same edge that computes the last bit;
          // sub/borrow stay untouched for the rest of the op.
          sub_next    = sr_shift;
          borrow_next = cell_bout;
          state_next  = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Reset also clears the held result, so an aborted op
  // leaves sub/borrow at zero rather than at the previous answer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sr_reg     <= '0;
      cnt_reg    <= '0;
      br_reg     <= 1'b0;
      sub_reg    <= '0;
      borrow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      sr_reg     <= sr_next;
      cnt_reg    <= cnt_next;
      br_reg     <= br_next;
      sub_reg    <= sub_next;
      borrow_reg <= borrow_next;
    end
  end

  // Outputs come only from registers or state decode.
  assign busy   = (state_reg == S_RUN);
  assign done   = (state_reg == S_DONE);
  assign sub    = sub_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Drives a WIDTH=8 and a WIDTH=1 instance of serial_sub_ctrl. Expected results
// come from plain integer subtraction (difference mod 2^WIDTH, borrow = a < b)
// and a per-op cycle count. Inputs change on falling edges; outputs are
// sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] sub;

  logic         start1;
  logic [0:0]   a1, b1;
  logic         busy1, done1, borrow1;
  logic [0:0]   sub1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the result the DUT should currently be holding.
  logic [W-1:0] exp_sub_q = '0;
  logic         exp_br_q  = 1'b0;

  serial_sub_ctrl #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sub(sub), .borrow(borrow)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sub(sub1), .borrow(borrow1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation. pulse_at >= 1 re-asserts start (with other
  // operands) for one cycle in that RUN cycle; it must be ignored.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int pulse_at);
    int           n, busy_n, hold_bad;
    logic [W-1:0] es;
    logic         eb;
    es = W'(int'(av) - int'(bv));
    eb = (av < bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    n = 1; busy_n = 0; hold_bad = 0;
    while (!done && n < 4 * W) begin
      if (busy) busy_n++;
      if (sub !== exp_sub_q || borrow !== exp_br_q) hold_bad++;
      if (n == pulse_at) begin
        start = 1'b1; a = 8'h00; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency_edges", 32'(n), 32'(W + 1));
    check_eq("busy_cycles", 32'(busy_n), 32'(W));
    check_eq("result_hold", 32'(hold_bad), 32'd0);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq("sub", 32'(sub), 32'(es));
    check_eq("borrow", 32'(borrow), 32'(eb));
    $display("op w8 a=0x%02h b=0x%02h -> sub=0x%02h borrow=%0d (exp 0x%02h/%0d) edges=%0d",
             av, bv, sub, borrow, es, eb, n);
    exp_sub_q = es;
    exp_br_q  = eb;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_op1(input int av, input int bv);
    int n;
    int es, eb;
    es = (av - bv) & 1;
    eb = (av < bv) ? 1 : 0;
    @(negedge clk);
    start1 = 1'b1; a1 = 1'(av); b1 = 1'(bv);
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("w1_latency_edges", 32'(n), 32'd2);
    check_eq("w1_sub", 32'(sub1), 32'(es));
    check_eq("w1_borrow", 32'(borrow1), 32'(eb));
    $display("op w1 a=%0d b=%0d -> sub=%0d borrow=%0d (exp %0d/%0d) edges=%0d",
             av, bv, sub1, borrow1, es, eb, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  last_t, ndone, bad;
    bit  seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sub", 32'(sub), 32'd0);
    check_eq("rst_borrow", 32'(borrow), 32'd0);
    check_eq("rst_w1_sub", 32'(sub1), 32'd0);
    rst = 1'b0;

    // Directed patterns.
    run_op(8'h5A, 8'h3C, -1);
    run_op(8'h10, 8'h20, -1);
    run_op(8'h00, 8'h01, -1);
    run_op(8'hFF, 8'hFF, -1);

    // Second start during RUN is ignored; nothing else happens afterwards.
    run_op(8'h80, 8'h01, 3);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check_eq("ignored_start_quiet", 32'(seen), 32'd0);

    // Abort mid-RUN with reset.
    run_op(8'h05, 8'h03, -1);
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk);
    start = 1'b0;                 // first RUN cycle
    repeat (3) @(negedge clk);    // fourth RUN cycle
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    check_eq("abort_hold_before", 32'(sub), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sub", 32'(sub), 32'd0);
    check_eq("abort_borrow", 32'(borrow), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    $display("op w8 abort a=0x33 b=0x11 -> sub=0x%02h borrow=%0d", sub, borrow);
    exp_sub_q = '0;
    exp_br_q  = 1'b0;
    run_op(8'h09, 8'h0A, -1);

    // start held high: back-to-back ops every W+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h40; b = 8'h20;
    last_t = -1; ndone = 0; bad = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (done) begin
        if (last_t >= 0 && (t - last_t) != W + 2) bad++;
        if (sub !== 8'h20 || borrow !== 1'b0) bad++;
        last_t = t;
        ndone++;
      end
    end
    start = 1'b0;
    check_eq("b2b_done_count", 32'(ndone), 32'd4);
    check_eq("b2b_spacing_and_result", 32'(bad), 32'd0);
    $display("op w8 back-to-back a=0x40 b=0x20 -> %0d done pulses, sub=0x%02h", ndone, sub);
    repeat (2 * W) @(negedge clk);  // drain the op still in flight
    exp_sub_q = 8'h20;
    exp_br_q  = 1'b0;

    // Randomized ops, some with an ignored mid-RUN start.
    for (int i = 0; i < 20; i++) begin
      int p;
      p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : -1;
      run_op(W'($urandom), W'($urandom), p);
    end

    // WIDTH=1 sweep plus random.
    run_op1(0, 0);
    run_op1(0, 1);
    run_op1(1, 0);
    run_op1(1, 1);
    for (int i = 0; i < 6; i++) begin
      run_op1(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
